// File: rtl/rf_exec_seq.sv
// Sequencer that reads two register-file operands, executes one ALU op and writes the result back.
// Define RF_EXEC_SEQ_MUL_EN to add a 32-cycle iterative shift-add multiply for opcode 8.
module rf_exec_seq #(
    parameter int unsigned IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [3:0]       in_rd,
    input  logic [3:0]       in_rs1,
    input  logic [3:0]       in_rs2,
    input  logic [IMM_W-1:0] in_imm,
    output logic             rf_EN,
    output logic             rf_RD,
    output logic             rf_WR,
    output logic [3:0]       rf_sel_o1,
    output logic [3:0]       rf_sel_o2,
    output logic [3:0]       rf_sel_i1,
    output logic [31:0]      rf_Ip1,
    input  logic [31:0]      rf_Op1,
    input  logic [31:0]      rf_Op2,
    output logic             done,
    output logic             err,
    output logic [31:0]      result
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SH_W   = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd6;
    localparam logic [OP_W-1:0] OP_ADDI = 4'd7;
`ifdef RF_EXEC_SEQ_MUL_EN
    localparam logic [OP_W-1:0] OP_MUL  = 4'd8;
    localparam int unsigned     CNT_W     = 5;
    localparam int unsigned     MUL_STEPS = 32;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_MUL,
        S_WRITE
    } state_t;

    state_t              r_state;
    logic [OP_W-1:0]     r_op;
    logic [IDX_W-1:0]    r_rd;
    logic [IMM_W-1:0]    r_imm;
    logic                r_in_ready;
    logic                r_rf_en;
    logic                r_rf_rd;
    logic                r_rf_wr;
    logic [IDX_W-1:0]    r_sel_o1;
    logic [IDX_W-1:0]    r_sel_o2;
    logic [IDX_W-1:0]    r_sel_i1;
    logic [DATA_W-1:0]   r_ip1;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_result;

    logic                w_legal;
    logic [DATA_W-1:0]   w_imm_sext;
    logic [DATA_W-1:0]   w_alu;

`ifdef RF_EXEC_SEQ_MUL_EN
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   w_acc_nx;

    assign w_acc_nx = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

    assign in_ready  = r_in_ready;
    assign rf_EN     = r_rf_en;
    assign rf_RD     = r_rf_rd;
    assign rf_WR     = r_rf_wr;
    assign rf_sel_o1 = r_sel_o1;
    assign rf_sel_o2 = r_sel_o2;
    assign rf_sel_i1 = r_sel_i1;
    assign rf_Ip1    = r_ip1;
    assign done      = r_done;
    assign err       = r_err;
    assign result    = r_result;

    assign w_imm_sext = DATA_W'($signed(r_imm));

    // Opcode decode at accept time
    always_comb begin
        w_legal = (in_op <= OP_ADDI);
`ifdef RF_EXEC_SEQ_MUL_EN
        if (in_op == OP_MUL) begin
            w_legal = 1'b1;
        end
`endif
    end

    // Single-cycle ALU on the operands returned during EXEC
    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_ADD:  w_alu = rf_Op1 + rf_Op2;
            OP_SUB:  w_alu = rf_Op1 - rf_Op2;
            OP_AND:  w_alu = rf_Op1 & rf_Op2;
            OP_OR:   w_alu = rf_Op1 | rf_Op2;
            OP_XOR:  w_alu = rf_Op1 ^ rf_Op2;
            OP_SLL:  w_alu = rf_Op1 << rf_Op2[SH_W-1:0];
            OP_SRL:  w_alu = rf_Op1 >> rf_Op2[SH_W-1:0];
            OP_ADDI: w_alu = rf_Op1 + w_imm_sext;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_rd       <= '0;
            r_imm      <= '0;
            r_in_ready <= 1'b1;
            r_rf_en    <= 1'b0;
            r_rf_rd    <= 1'b0;
            r_rf_wr    <= 1'b0;
            r_sel_o1   <= '0;
            r_sel_o2   <= '0;
            r_sel_i1   <= '0;
            r_ip1      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_result   <= '0;
`ifdef RF_EXEC_SEQ_MUL_EN
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
`endif
        end else begin
            r_rf_en <= 1'b1;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op  <= in_op;
                        r_rd  <= in_rd;
                        r_imm <= in_imm;
                        if (w_legal) begin
                            r_state    <= S_READ;
                            r_in_ready <= 1'b0;
                            r_rf_rd    <= 1'b1;
                            r_sel_o1   <= in_rs1;
                            r_sel_o2   <= in_rs2;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_rf_rd <= 1'b0;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
`ifdef RF_EXEC_SEQ_MUL_EN
                    if (r_op == OP_MUL) begin
                        r_mcand  <= rf_Op1;
                        r_mplier <= rf_Op2;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_MUL;
                    end else
`endif
                    begin
                        r_ip1    <= w_alu;
                        r_result <= w_alu;
                        r_sel_i1 <= r_rd;
                        r_rf_wr  <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= S_WRITE;
                    end
                end
`ifdef RF_EXEC_SEQ_MUL_EN
                // One multiplier bit per cycle; the final step feeds WRITE directly
                S_MUL: begin
                    r_acc    <= w_acc_nx;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(MUL_STEPS - 1)) begin
                        r_ip1    <= w_acc_nx;
                        r_result <= w_acc_nx;
                        r_sel_i1 <= r_rd;
                        r_rf_wr  <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= S_WRITE;
                    end
                end
`endif
                S_WRITE: begin
                    r_rf_wr    <= 1'b0;
                    r_done     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_rf_rd    <= 1'b0;
                    r_rf_wr    <= 1'b0;
                    r_done     <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_exec_seq.sv
// Bench for rf_exec_seq: behavioural register file plus arithmetic reference model,
// directed corner vectors followed by random operations.
module tb_rf_exec_seq;

    localparam int unsigned IMM_W = 16;
`ifdef RF_EXEC_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [3:0]       in_rd;
    logic [3:0]       in_rs1;
    logic [3:0]       in_rs2;
    logic [IMM_W-1:0] in_imm;
    logic             rf_EN;
    logic             rf_RD;
    logic             rf_WR;
    logic [3:0]       rf_sel_o1;
    logic [3:0]       rf_sel_o2;
    logic [3:0]       rf_sel_i1;
    logic [31:0]      rf_Ip1;
    logic [31:0]      rf_Op1;
    logic [31:0]      rf_Op2;
    logic             done;
    logic             err;
    logic [31:0]      result;

    logic [31:0]      mem [16];
    logic             ld_en;
    logic [3:0]       ld_addr;
    logic [31:0]      ld_data;

    int               total = 0;
    int               bad = 0;
    logic [31:0]      exp_rf [16];
    logic [31:0]      exp_result;

    always #5 clk = ~clk;

    rf_exec_seq #(.IMM_W(IMM_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .rf_EN     (rf_EN),
        .rf_RD     (rf_RD),
        .rf_WR     (rf_WR),
        .rf_sel_o1 (rf_sel_o1),
        .rf_sel_o2 (rf_sel_o2),
        .rf_sel_i1 (rf_sel_i1),
        .rf_Ip1    (rf_Ip1),
        .rf_Op1    (rf_Op1),
        .rf_Op2    (rf_Op2),
        .done      (done),
        .err       (err),
        .result    (result)
    );

    // Register file: read data appears the cycle after rf_RD, writes land at the edge
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (rf_WR) begin
            mem[rf_sel_i1] <= rf_Ip1;
        end
        if (rf_RD) begin
            rf_Op1 <= mem[rf_sel_o1];
            rf_Op2 <= mem[rf_sel_o2];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("rd_wr_excl", 32'(rf_RD & rf_WR), 32'd0);
    endtask

    function automatic bit is_legal(input logic [3:0] op);
        return (op < 4'd8) || (MUL_EN && op == 4'd8);
    endfunction

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [IMM_W-1:0] imm);
        logic [31:0] imm32;
        imm32 = 32'($signed(imm));
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << (b % 32);
            4'd6:    return a >> (b % 32);
            4'd7:    return a + imm32;
            4'd8:    return a * b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
        exp_rf[a] = d;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                          input logic [3:0] rs2, input logic [IMM_W-1:0] imm);
        logic [31:0] e;
        chk("ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        tick();
        in_op    = 4'($urandom);
        in_rd    = 4'($urandom);
        in_rs1   = 4'($urandom);
        in_rs2   = 4'($urandom);
        in_imm   = IMM_W'($urandom);
        if (!is_legal(op)) begin
            in_valid = 1'b0;
            chk("ill_err", 32'(err), 32'd1);
            chk("ill_rd", 32'(rf_RD), 32'd0);
            chk("ill_wr", 32'(rf_WR), 32'd0);
            chk("ill_done", 32'(done), 32'd0);
            chk("ill_ready", 32'(in_ready), 32'd1);
            chk("ill_result", result, exp_result);
            tick();
            chk("ill_err_clr", 32'(err), 32'd0);
            chk("ill_rd2", 32'(rf_RD), 32'd0);
            return;
        end
        e = ref_op(op, exp_rf[rs1], exp_rf[rs2], imm);
        // Busy cycles: keep offering garbage requests that must be ignored
        in_valid = 1'b1;
        chk("read_rd", 32'(rf_RD), 32'd1);
        chk("read_sel1", 32'(rf_sel_o1), 32'(rs1));
        chk("read_sel2", 32'(rf_sel_o2), 32'(rs2));
        chk("read_ready", 32'(in_ready), 32'd0);
        chk("read_err", 32'(err), 32'd0);
        tick();
        chk("exec_rd", 32'(rf_RD), 32'd0);
        chk("exec_wr", 32'(rf_WR), 32'd0);
        chk("exec_done", 32'(done), 32'd0);
        if (op == 4'd8) begin
            repeat (32) begin
                tick();
                chk("mul_busy", 32'({rf_WR, done, in_ready}), 32'd0);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("wr_wr", 32'(rf_WR), 32'd1);
        chk("wr_sel", 32'(rf_sel_i1), 32'(rd));
        chk("wr_data", rf_Ip1, e);
        chk("wr_done", 32'(done), 32'd1);
        chk("wr_result", result, e);
        exp_rf[rd] = e;
        exp_result = e;
        tick();
        chk("post_ready", 32'(in_ready), 32'd1);
        chk("post_done", 32'(done), 32'd0);
        chk("post_wr", 32'(rf_WR), 32'd0);
        chk("post_result", result, e);
        chk("post_mem", mem[rd], e);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_rd    = 4'd2;
        in_rs1   = 4'd0;
        in_rs2   = 4'd1;
        in_imm   = '0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        exp_result = 32'd0;
        for (int i = 0; i < 16; i++) exp_rf[i] = 32'd0;

        // Reset with a request pending: it must not be accepted
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_en", 32'(rf_EN), 32'd0);
        chk("rst_rd", 32'(rf_RD), 32'd0);
        chk("rst_wr", 32'(rf_WR), 32'd0);
        chk("rst_sel", 32'({rf_sel_o1, rf_sel_o2, rf_sel_i1}), 32'd0);
        chk("rst_ip1", rf_Ip1, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_result", result, 32'd0);
        tick();
        chk("en_after_rst", 32'(rf_EN), 32'd1);
        chk("no_accept_rst", 32'(rf_RD), 32'd0);

        for (int i = 0; i < 16; i++) load(4'(i), 32'd0);

        load(4'd0, 32'hABCDEFAB);
        load(4'd1, 32'h01234567);
        run_op(4'd0, 4'd2, 4'd0, 4'd1, '0);
        chk("vec_add", result, 32'hACF13512);

        load(4'd3, 32'h00000000);
        load(4'd4, 32'h00000001);
        run_op(4'd1, 4'd5, 4'd3, 4'd4, '0);
        chk("vec_sub", result, 32'hFFFFFFFF);

        load(4'd6, 32'h7FFFFFFF);
        run_op(4'd7, 4'd6, 4'd6, 4'd9, 16'hFFFF);
        chk("vec_addi", result, 32'h7FFFFFFE);

        load(4'd7, 32'h00000001);
        load(4'd8, 32'h00000021);
        run_op(4'd5, 4'd13, 4'd7, 4'd8, '0);
        chk("vec_sll", result, 32'h00000002);

        load(4'd9, 32'h80000000);
        load(4'd10, 32'd31);
        run_op(4'd6, 4'd14, 4'd9, 4'd10, '0);
        chk("vec_srl", result, 32'h00000001);

        run_op(4'd12, 4'd15, 4'd0, 4'd1, '0);
        chk("vec_ill_keep", result, 32'h00000001);

        load(4'd11, 32'h00010001);
        load(4'd12, 32'h00010001);
        run_op(4'd8, 4'd15, 4'd11, 4'd12, '0);
        if (MUL_EN) chk("vec_mul", result, 32'h00020001);
        else        chk("vec_mul_ill", result, 32'h00000001);

        // Destination aliases both sources: operands are pre-write values
        load(4'd4, 32'h11112222);
        run_op(4'd0, 4'd4, 4'd4, 4'd4, '0);
        chk("vec_alias", result, 32'h22224444);

        // Reset while an ADD sits in EXEC
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_rd    = 4'd2;
        in_rs1   = 4'd0;
        in_rs2   = 4'd1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_result = 32'd0;
        chk("rexec_ready", 32'(in_ready), 32'd1);
        chk("rexec_wr", 32'(rf_WR), 32'd0);
        chk("rexec_done", 32'(done), 32'd0);
        chk("rexec_result", result, 32'd0);
        chk("rexec_en", 32'(rf_EN), 32'd0);
        tick();
        chk("rexec_wr2", 32'(rf_WR), 32'd0);
        chk("rexec_mem", mem[2], exp_rf[2]);
        chk("rexec_en2", 32'(rf_EN), 32'd1);

        // Random operations against the reference model
        for (int i = 0; i < 16; i++) load(4'(i), $urandom);
        for (int n = 0; n < 30; n++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
                   IMM_W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_exec_seq.md
RF_EXEC_SEQ -- requirements
Module: rf_exec_seq

Interface
REQ-001 SHALL have parameter IMM_W, default 16, ADDI immediate width, sign-extended to 32.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: in_valid  in  1  op request; in_ready  out  1  op accepted when both high at a clk edge.
REQ-005 SHALL have ports: in_op  in  4  opcode; in_rd, in_rs1, in_rs2  in  4 each  register indices; in_imm  in  IMM_W  immediate.
REQ-006 SHALL have ports: rf_EN, rf_RD, rf_WR  out  1 each  register-file enable/read/write strobes.
REQ-007 SHALL have ports: rf_sel_o1, rf_sel_o2, rf_sel_i1  out  4 each  read/write selects; rf_Ip1  out  32  write data.
REQ-008 SHALL have ports: rf_Op1, rf_Op2  in  32 each  register-file read data.
REQ-009 SHALL have ports: done  out  1  completion pulse; err  out  1  illegal-op pulse; result  out  32  last written value.

Function
REQ-010 SHALL implement FSM states IDLE, READ, EXEC, MUL, WRITE; in_ready SHALL be 1 only in IDLE.
REQ-011 On accept in IDLE, SHALL latch op/rd/rs1/rs2/imm and enter READ next cycle (legal op) or stay IDLE (illegal op).
REQ-012 READ (one cycle): rf_RD=1, rf_sel_o1=rs1, rf_sel_o2=rs2; next state EXEC.
REQ-013 EXEC (one cycle): SHALL sample rf_Op1/rf_Op2 (valid one cycle after rf_RD) and register the result; next state WRITE, or MUL for op 8.
REQ-014 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL (logical), 7 ADDI (Op1 + sext(imm)), 8 MUL; 9-15 illegal.
REQ-015 ADD/SUB/ADDI SHALL wrap modulo 2^32, no flags; SLL/SRL shift by Op2[4:0] only.
REQ-016 WRITE (one cycle): rf_WR=1, rf_sel_i1=rd, rf_Ip1=result; done=1 same cycle; next state IDLE.
REQ-017 Legal non-MUL latency: accept edge N -> READ cycle N+1, EXEC N+2, WRITE/done N+3, in_ready=1 at N+4.
REQ-018 Illegal op: err=1 for exactly the cycle after accept, no rf_RD/rf_WR, no done, result unchanged, in_ready stays 1.
REQ-019 rf_RD and rf_WR SHALL never be high together; rf_RD low outside READ, rf_WR low outside WRITE.
REQ-020 rf_EN SHALL be 1 in every state after reset; result SHALL hold its value until the next WRITE.
REQ-021 rd == rs1 or rs2 SHALL be legal; operands are the pre-write values.
REQ-022 in_valid/in_* changes while not IDLE SHALL be ignored.

Reset
REQ-023 rst high at a clk edge SHALL force IDLE from any state including MUL, discarding the operation with no write.
REQ-024 Reset values: in_ready=1 after reset cycle, rf_EN=0 during reset, rf_RD=0, rf_WR=0, all selects=0, rf_Ip1=0, done=0, err=0, result=0.
REQ-025 rst high for one cycle SHALL suffice; in_valid during rst SHALL not be accepted.

Configuration
REQ-026 Macro RF_EXEC_SEQ_MUL_EN defined: op 8 SHALL do iterative shift-add, MUL state exactly 32 cycles, result = low 32 bits of Op1*Op2 (unsigned), then WRITE; done at N+35.
REQ-027 Macro RF_EXEC_SEQ_MUL_EN undefined: op 8 SHALL be illegal per REQ-018 and no multiplier logic SHALL exist.

Verification
REQ-028 Reset then ADD rs1=0 (0xABCDEFAB), rs2=1 (0x01234567), rd=2 -> rf_WR at N+3, sel_i1=2, rf_Ip1=0xACF13512, done one cycle.
REQ-029 SUB 0x00000000 - 0x00000001 -> result 0xFFFFFFFF; ADDI 0x7FFFFFFF + imm 0xFFFF -> 0x7FFFFFFE.
REQ-030 SLL Op1=0x00000001, Op2=0x00000021 -> 0x00000002; SRL Op1=0x80000000, Op2=31 -> 0x00000001.
REQ-031 in_op=12 -> err pulse at N+1, no rf_RD/rf_WR, in_ready stays 1, result unchanged.
REQ-032 rst asserted during EXEC of an ADD -> next cycle IDLE, rf_WR never 1, result=0.
REQ-033 With macro: MUL 0x00010001 * 0x00010001 -> 0x00020001 with done at N+35; without macro: same op -> err only.
